// File: rtl/tv_sequencer_if.sv
// Bundle between the vector sequencer and its environment: start/status,
// vector ROM read port and the stimulus/response pins of the device under test.
interface tv_sequencer_if #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int ADDR_W = 10
);
    localparam int VEC_W = 1 + IN_W + OUT_W;

    // start is a single-cycle request, honoured only while the sequencer is
    // idle or done; done is a level that stays high until the next accepted
    // start or reset. The ROM read port has no back-pressure: data for
    // rom_addr is returned exactly one clock later.
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [VEC_W-1:0]  rom_data;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [31:0]       vectornum;
    logic [31:0]       errors;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_idx;
    logic [2:0]        dbg_state;

    modport master (
        input  start, rom_data, dut_out,
        output rom_addr, dut_in, busy, done, pass, vectornum, errors,
               fail_valid, fail_idx, dbg_state
    );

    modport slave (
        output start, rom_data, dut_out,
        input  rom_addr, dut_in, busy, done, pass, vectornum, errors,
               fail_valid, fail_idx, dbg_state
    );
endinterface

// File: rtl/tv_sequencer.sv
// Hardware test-vector sequencer: walks a synchronous vector ROM, drives a DUT,
// waits a settle time, compares its response and reports vector/error counts.
module tv_sequencer #(
    parameter int IN_W          = 3,
    parameter int OUT_W         = 1,
    parameter int ADDR_W        = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    tv_sequencer_if.master bus
);
    localparam int VEC_W = 1 + IN_W + OUT_W;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [IN_W-1:0]   r_dut_in;
    logic [OUT_W-1:0]  r_exp;
    logic [SET_W-1:0]  r_settle;
    logic [31:0]       r_vectornum;
    logic [31:0]       r_errors;
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_fail_idx;

    logic              w_start_ok;
    logic              w_vec_valid;
    logic [IN_W-1:0]   w_vec_in;
    logic [OUT_W-1:0]  w_vec_exp;
    logic              w_mismatch;
    logic              w_last_addr;

    assign w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_vec_valid = bus.rom_data[VEC_W-1];
    assign w_vec_in    = bus.rom_data[VEC_W-2:OUT_W];
    assign w_vec_exp   = bus.rom_data[OUT_W-1:0];
    assign w_mismatch  = (bus.dut_out != r_exp);
    assign w_last_addr = (r_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_FETCH;
            S_FETCH:  w_next = S_LOAD;
            // A cleared valid bit terminates the run without being counted.
            S_LOAD:   w_next = w_vec_valid ? S_SETTLE : S_DONE;
            S_SETTLE: if (r_settle == '0) w_next = S_CHECK;
            // The last ROM address ends the run instead of wrapping to 0.
            S_CHECK:  w_next = w_last_addr ? S_DONE : S_FETCH;
            S_DONE:   if (w_start_ok) w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_dut_in     <= '0;
            r_exp        <= '0;
            r_settle     <= '0;
            r_vectornum  <= '0;
            r_errors     <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
        end else if (w_start_ok) begin
            // dut_in deliberately keeps the last stimulus until vector 0 loads.
            r_addr       <= '0;
            r_vectornum  <= '0;
            r_errors     <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_vec_valid) begin
                        r_dut_in <= w_vec_in;
                        r_exp    <= w_vec_exp;
                        r_settle <= SET_W'(SETTLE_CYCLES - 1);
                    end
                end
                S_SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_errors != 32'hFFFF_FFFF) begin
                            r_errors <= r_errors + 32'd1;
                        end
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_idx   <= r_addr;
                        end
                    end
                    r_vectornum <= r_vectornum + 32'd1;
                    if (!w_last_addr) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The ROM address is the live counter so it reads 0 straight out of reset.
    assign bus.rom_addr   = r_addr;
    assign bus.dut_in     = r_dut_in;
    assign bus.busy       = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                            (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign bus.done       = (r_state == S_DONE);
    assign bus.pass       = (r_state == S_DONE) && (r_errors == 32'd0);
    assign bus.vectornum  = r_vectornum;
    assign bus.errors     = r_errors;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_idx   = r_fail_idx;
    assign bus.dbg_state  = r_state;
endmodule
